// File: rtl/note_gfx_pkg.sv
// Shared constants and types for the note-glyph graphics path: sprite geometry,
// screen size, glyph identifiers and the blitter sequencer states.
package note_gfx_pkg;

  localparam int SPR_W      = 20;
  localparam int SPR_H      = 30;
  localparam int SPR_PIXELS = SPR_W * SPR_H;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;

  typedef enum logic [2:0] {
    QUARTER_UP,
    QUARTER_DOWN,
    EIGHTH_UP,
    EIGHTH_DOWN,
    HALF_UP,
    HALF_DOWN,
    WHOLE,
    REST_Q
  } glyph_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } blitter_state_t;

endpackage

// File: rtl/note_sprite_blitter.sv
// Copies one SPR_W x SPR_H monochrome glyph from the selected ROM into the staff
// framebuffer at (x,y), clipping at the screen edges, with draw/erase/transparent modes.
module note_sprite_blitter
  import note_gfx_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SPR_W    = 20,
  parameter int SPR_H    = 30,
  parameter int SEL_W    = 3,
  parameter int FB_AW    = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [9:0]       cmd_x,
  input  logic [8:0]       cmd_y,
  input  logic             cmd_erase,
  input  logic             cmd_transparent,
  output logic [SEL_W-1:0] rom_sel,
  output logic [9:0]       rom_addr,
  input  logic             rom_pixel,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic             fb_data,
  output logic             busy,
  output logic             done
);

  localparam int CW    = $clog2(SPR_W);
  localparam int RW    = $clog2(SPR_H);
  localparam int LIN_W = 21;

  blitter_state_t state;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic           drain_cnt;
  logic           accept;
  logic           col_last;
  logic           last_addr;

  logic [9:0]     x_q;
  logic [8:0]     y_q;
  logic           erase_q;
  logic           transp_q;

  logic             vld_p1;
  logic [10:0]      px_p1;
  logic [9:0]       py_p1;
  logic             in_bounds_p1;
  logic [LIN_W-1:0] lin_p1;

  assign accept    = cmd_valid && cmd_ready;
  assign col_last  = (col == CW'(SPR_W - 1));
  assign last_addr = col_last && (row == RW'(SPR_H - 1));

  // Stage p0: sequencer issues one ROM address per cycle while in RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      col       <= '0;
      row       <= '0;
      drain_cnt <= 1'b0;
      rom_addr  <= '0;
      rom_sel   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state     <= RUN;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            col       <= '0;
            row       <= '0;
            rom_addr  <= '0;
            rom_sel   <= cmd_sel;
          end else begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        RUN: begin
          if (last_addr) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            rom_addr <= rom_addr + 10'd1;
            if (col_last) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Two cycles let the ROM read and the output register flush the last pixel
          if (drain_cnt) begin
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      x_q      <= cmd_x;
      y_q      <= cmd_y;
      erase_q  <= cmd_erase;
      transp_q <= cmd_transparent;
    end
  end

  // Stage p1: screen coordinates line up with the registered ROM pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= (state == RUN);
    end
  end

  always_ff @(posedge clk) begin
    px_p1 <= {1'b0, x_q} + 11'(col);
    py_p1 <= {1'b0, y_q} + 10'(row);
  end

  always_comb begin
    in_bounds_p1 = (px_p1 < 11'(SCREEN_W)) && (py_p1 < 10'(SCREEN_H));
    lin_p1       = LIN_W'(py_p1) * LIN_W'(SCREEN_W) + LIN_W'(px_p1);
  end

  // Stage p2: registered framebuffer write port
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= 1'b0;
    end else begin
      fb_we   <= vld_p1 && in_bounds_p1 && (rom_pixel || !(erase_q || transp_q));
      fb_addr <= lin_p1[FB_AW-1:0];
      fb_data <= !erase_q && (transp_q || rom_pixel);
    end
  end

endmodule

// File: tb/tb_note_sprite_blitter.sv
// Directed bench for note_sprite_blitter with a behavioural glyph ROM and a write scoreboard.
module tb_note_sprite_blitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_sel;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic        cmd_erase;
  logic        cmd_transparent;
  logic [2:0]  rom_sel;
  logic [9:0]  rom_addr;
  logic        rom_pixel;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic        fb_data;
  logic        busy;
  logic        done;

  note_sprite_blitter dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_erase(cmd_erase), .cmd_transparent(cmd_transparent),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_pixel(rom_pixel),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  int rom_mode = 0;

  typedef struct {
    int   cyc;
    int   addr;
    logic data;
  } wr_t;
  wr_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: all ones, 1: checkerboard, other: irregular pattern
  function automatic logic rom_fn(input int mode, input int a);
    int r, c;
    r = a / 20;
    c = a % 20;
    case (mode)
      0:       return 1'b1;
      1:       return ((r + c) % 2) == 0;
      default: return ((r * 7 + c * 3) % 5) < 2;
    endcase
  endfunction

  always @(posedge clk) rom_pixel <= rom_fn(rom_mode, int'(rom_addr));

  always @(negedge clk) begin : monitor
    wr_t e;
    if (fb_we) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("fb_we_unexpected", 64'(fb_we), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
        check("wr_addr", 64'(fb_addr), 64'(e.addr));
        check("wr_data", 64'(fb_data), 64'(e.data));
      end
    end
  end

  task automatic push_expect(input int t0, input int x, input int y, input logic er,
                             input logic tr, input int max_rel);
    int k, px, py;
    logic p, we, d;
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 20; c++) begin
        k  = r * 20 + c;
        p  = rom_fn(rom_mode, k);
        px = x + c;
        py = y + r;
        we = er ? p : (tr ? p : 1'b1);
        d  = er ? 1'b0 : (tr ? 1'b1 : p);
        if (px < 640 && py < 480 && we && (k + 3) <= max_rel)
          exp_q.push_back('{cyc: t0 + k + 3, addr: py * 640 + px, data: d});
      end
    end
  endtask

  task automatic drive_cmd(input logic [2:0] sel, input int x, input int y,
                           input logic er, input logic tr);
    cmd_sel         = sel;
    cmd_x           = 10'(x);
    cmd_y           = 9'(y);
    cmd_erase       = er;
    cmd_transparent = tr;
    cmd_valid       = 1'b1;
  endtask

  // Called on a negedge with the block idle; returns in cycle t0+1
  task automatic issue(input logic [2:0] sel, input int x, input int y, input logic er,
                       input logic tr, input int max_rel, output int t0);
    drive_cmd(sel, x, y, er, tr);
    t0 = cyc;
    push_expect(t0, x, y, er, tr, max_rel);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int t0, input logic [2:0] sel);
    int dcount = 0;
    int dcyc   = -1;
    int selbad = 0;
    for (int i = 0; i < 620; i++) begin
      if (cyc == t0 + 1) begin
        check("start_busy", 64'(busy), 64'(1));
        check("start_ready", 64'(cmd_ready), 64'(0));
        check("start_rom_addr", 64'(rom_addr), 64'(0));
      end
      if (cyc == t0 + 600) check("last_rom_addr", 64'(rom_addr), 64'(599));
      if (busy && rom_sel !== sel) selbad++;
      if (done) begin
        dcount++;
        if (dcyc < 0) begin
          dcyc = cyc;
          check("done_busy", 64'(busy), 64'(0));
          check("done_ready", 64'(cmd_ready), 64'(1));
        end
      end
      @(negedge clk);
    end
    check("done_cycle", 64'(dcyc), 64'(t0 + 603));
    check("done_count", 64'(dcount), 64'(1));
    check("rom_sel_stable", 64'(selbad), 64'(0));
    check("queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, t1, w0, rdy_cyc, dcount;
    reset           = 1'b1;
    cmd_valid       = 1'b0;
    cmd_sel         = 3'd0;
    cmd_x           = '0;
    cmd_y           = '0;
    cmd_erase       = 1'b0;
    cmd_transparent = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_fb_we", 64'(fb_we), 64'(0));
    check("rst_fb_addr", 64'(fb_addr), 64'(0));
    check("rst_fb_data", 64'(fb_data), 64'(0));
    check("rst_rom_addr", 64'(rom_addr), 64'(0));
    check("rst_rom_sel", 64'(rom_sel), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Full opaque draw, all-ones glyph
    rom_mode = 0;
    w0 = wr_count;
    issue(3'd2, 100, 50, 1'b0, 1'b0, 1000, t0);
    wait_done(t0, 3'd2);
    check("full_wr_count", 64'(wr_count - w0), 64'(600));

    // Transparent checkerboard at the origin
    rom_mode = 1;
    w0 = wr_count;
    issue(3'd0, 0, 0, 1'b0, 1'b1, 1000, t0);
    wait_done(t0, 3'd0);
    check("transp_wr_count", 64'(wr_count - w0), 64'(300));

    // Clipping at the bottom-right corner
    rom_mode = 0;
    w0 = wr_count;
    issue(3'd5, 630, 470, 1'b0, 1'b0, 1000, t0);
    wait_done(t0, 3'd5);
    check("clip_wr_count", 64'(wr_count - w0), 64'(100));

    // Erase
    w0 = wr_count;
    issue(3'd7, 200, 100, 1'b1, 1'b0, 1000, t0);
    wait_done(t0, 3'd7);
    check("erase_wr_count", 64'(wr_count - w0), 64'(600));

    // Opaque draw of an irregular glyph: zero pixels are written too
    rom_mode = 2;
    w0 = wr_count;
    issue(3'd3, 50, 20, 1'b0, 1'b0, 1000, t0);
    wait_done(t0, 3'd3);
    check("opaque_wr_count", 64'(wr_count - w0), 64'(600));

    // Backpressure: second command held from cycle 10
    rom_mode = 0;
    issue(3'd1, 300, 200, 1'b0, 1'b0, 1000, t0);
    while (cyc < t0 + 10) @(negedge clk);
    drive_cmd(3'd4, 400, 300, 1'b0, 1'b1);
    push_expect(t0 + 603, 400, 300, 1'b0, 1'b1, 1000);
    rdy_cyc = -1;
    for (int i = 0; i < 700 && rdy_cyc < 0; i++) begin
      if (cmd_ready) rdy_cyc = cyc;
      else @(negedge clk);
    end
    check("bp_ready_cycle", 64'(rdy_cyc), 64'(t0 + 603));
    check("bp_first_done", 64'(done), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    t1 = t0 + 603;
    wait_done(t1, 3'd4);

    // Reset in the middle of a command
    rom_mode = 0;
    issue(3'd6, 10, 10, 1'b0, 1'b0, 200, t0);
    while (cyc < t0 + 200) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_fb_we", 64'(fb_we), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_ready", 64'(cmd_ready), 64'(1));
    dcount = 0;
    for (int i = 0; i < 450; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(dcount), 64'(0));
    check("abort_queue_empty", 64'(exp_q.size()), 64'(0));

    w0 = wr_count;
    issue(3'd2, 100, 50, 1'b0, 1'b0, 1000, t0);
    wait_done(t0, 3'd2);
    check("post_reset_wr_count", 64'(wr_count - w0), 64'(600));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_sprite_blitter.md
Name: note_sprite_blitter

Overview:
Sequencer that copies one 20x30 monochrome note sprite from the note-glyph ROMs into the staff framebuffer at a given (x,y) position. It accepts draw/erase commands over a valid/ready handshake, scans the sprite in row-major order, and selects which glyph ROM drives the shared pixel bus. It compensates for the 1-cycle registered ROM read and clips at screen edges. It sits between the score/note scheduler and the framebuffer write port.

Parameters:
SCREEN_W, 640, framebuffer width in pixels
SCREEN_H, 480, framebuffer height in pixels
SPR_W, 20, sprite width
SPR_H, 30, sprite height
SEL_W, 3, glyph-select width (up to 8 ROMs)
FB_AW, 19, framebuffer address width (y*SCREEN_W + x)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block idle and able to accept
cmd_sel  in  SEL_W  glyph ROM index
cmd_x  in  10  sprite top-left column
cmd_y  in  9  sprite top-left row
cmd_erase  in  1  1 = erase (write 0 where sprite pixel is 1)
cmd_transparent  in  1  1 = write only set pixels; 0 = write every in-bounds pixel
rom_sel  out  SEL_W  glyph ROM select (external mux)
rom_addr  out  10  sprite address, row*SPR_W+col
rom_pixel  in  1  muxed ROM data, valid 1 cycle after rom_addr
fb_we  out  1  framebuffer write strobe
fb_addr  out  FB_AW  framebuffer write address
fb_data  out  1  framebuffer write data
busy  out  1  command in progress
done  out  1  1-cycle pulse on completion

Behaviour:
- Reset: state IDLE; cmd_ready=1, busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, rom_addr=0, rom_sel=0. Reset mid-command aborts immediately: no further writes, no done pulse.
- Accept when cmd_valid&&cmd_ready at a clock edge (E0); latch sel/x/y/erase/transparent; cmd_ready=0, busy=1 from cycle 1.
- States: IDLE -> RUN (on accept) -> DRAIN (after address 599 issued) -> DONE (1 cycle) -> IDLE.
- RUN: registered col/row counters; address k = row*SPR_W+col driven in cycle k+1 (k=0..599); col wraps at SPR_W-1 and row increments; the last address is row 29, col 19.
- Pipeline: rom_pixel for k is valid in cycle k+2; fb_* are registered and present in cycle k+3. Per-pixel coordinates are delayed alongside.
- Write rule for pixel p at (x+col, y+row):
  - If out of bounds (x+col >= SCREEN_W or y+row >= SCREEN_H): fb_we=0. Compute sums at 11/10 bits; there is no wrap.
  - If erase: fb_we=p, fb_data=0.
  - Else if transparent: fb_we=p, fb_data=1.
  - Else: fb_we=1, fb_data=p.
- fb_addr = (y+row)*SCREEN_W + (x+col), truncated to FB_AW. It is only meaningful when fb_we=1.
- DRAIN lasts 2 cycles. The last write is in cycle 602. DONE is cycle 603: done=1, busy=0, cmd_ready=1. A new command may be accepted at the end of cycle 603.
- cmd_valid while busy is ignored (not latched). The requester holds it until ready.
- rom_sel stays stable for the whole command; it keeps its last value in IDLE.

Decomposition:
- Shared package note_gfx_pkg holds:
  - constants SPR_W, SPR_H, SPR_PIXELS=600, SCREEN_W, SCREEN_H;
  - glyph enum (QUARTER_UP, QUARTER_DOWN, EIGHTH_UP, EIGHTH_DOWN, HALF_UP, HALF_DOWN, WHOLE, REST_Q);
  - blitter_state_t (IDLE, RUN, DRAIN, DONE).
- The blitter itself is one module with no sub-module. The external glyph ROM mux (glyph_rom_bank) is its own module, instantiated at top level.

Test Plan:
- Full draw: sel=2, x=100, y=50, opaque, ROM model all-ones -> 600 writes on cycles 3..602, first fb_addr=32100, last fb_addr=50679, fb_data=1, done at cycle 603 only.
- Transparent: checkerboard ROM model, (0,0) -> exactly 300 writes, all fb_data=1, at addresses where (row+col) is even.
- Clipping: x=630, y=470, opaque -> 100 writes (cols 0..9, rows 0..9), no address ≥ 307200, done still at cycle 603.
- Erase: all-ones ROM model, (200,100), erase=1 -> 600 writes with fb_data=0; rom_sel equals cmd_sel throughout.
- Backpressure: second cmd_valid asserted at cycle 10 and held -> cmd_ready=0 until cycle 603; accepted at the end of cycle 603; second write burst starts at cycle 606.
- Reset at cycle 200 -> from cycle 201 fb_we=0, busy=0, cmd_ready=1; no done pulse; a following command behaves as a full draw.
